// File: rtl/itr_ctrl.sv
// itr_ctrl: vectored, prioritised interrupt controller.
//
// NSRC rising-edge sources each set a pending latch. The lowest-index
// pending-and-enabled source wins and is requested from the core with its
// vector address ITRBASE + id*VSTEP. The controller then tracks in-service
// sources until the core returns from the interrupt.
//
// Optional feature macro: ITR_NEST_EN
//   defined   - a strictly higher-priority source may preempt the one in
//               service (nested in-service stack, depth NSRC).
//   undefined - one source in service at a time; new requests wait for the
//               return-from-interrupt.
module itr_ctrl #(
    parameter int NSRC    = 4,
    parameter int MINSTW  = 9,
    parameter int ITRBASE = 1,
    parameter int VSTEP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src,
    input  logic              mask_wr,
    input  logic [NSRC-1:0]   mask_in,
    output logic [NSRC-1:0]   mask_out,
    output logic [NSRC-1:0]   pend,
    output logic              itr,
    output logic [MINSTW-1:0] itr_addr,
    input  logic              itr_ack,
    input  logic              itr_ret,
    output logic              busy
);

    localparam int IDW = $clog2(NSRC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } state_t;

    // Vector address of a source, truncated to the instruction address width.
    function automatic logic [MINSTW-1:0] vec_addr(input logic [IDW-1:0] id);
        logic [31:0] a;
        a = 32'(ITRBASE) + 32'(id) * 32'(VSTEP);
        return a[MINSTW-1:0];
    endfunction

    // Registered state
    state_t            r_state;
    logic [NSRC-1:0]   r_src_d;
    logic [NSRC-1:0]   r_pend;
    logic [NSRC-1:0]   r_mask;
    // In-service set. Every push has a strictly lower index than the current
    // top, so the stack is always sorted by priority: the top is simply the
    // lowest set bit, a pop clears that bit, and no source can appear twice.
    // Without nesting at most one bit is ever set (depth 1).
    logic [NSRC-1:0]   r_insvc;
    logic [IDW-1:0]    r_id;
    logic              r_itr;
    logic [MINSTW-1:0] r_itr_addr;

    // Combinational
    state_t            w_state_next;
    logic [NSRC-1:0]   w_rise;
    logic [NSRC-1:0]   w_elig;
    logic              w_any_elig;
    logic [IDW-1:0]    w_win_id;
    logic [NSRC-1:0]   w_pend_clr;
    logic [NSRC-1:0]   w_pend_next;
    logic [NSRC-1:0]   w_insvc_next;
    logic [IDW-1:0]    w_id_next;
    logic              w_itr_next;
    logic [MINSTW-1:0] w_addr_next;
`ifdef ITR_NEST_EN
    logic [IDW-1:0]    w_top_id;
`endif

    assign w_rise     = src & ~r_src_d;
    assign w_elig     = r_pend & r_mask;
    assign w_any_elig = |w_elig;

    // Per-source pending latch: a new edge overrides a same-cycle clear.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            assign w_pend_next[gi] = w_rise[gi] | (r_pend[gi] & ~w_pend_clr[gi]);
        end
    endgenerate

    // Fixed-priority encoder: lowest eligible index wins.
    always_comb begin
        w_win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_id = IDW'(i);
            end
        end
    end

`ifdef ITR_NEST_EN
    // Top of the in-service stack = highest-priority source in service.
    always_comb begin
        w_top_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (r_insvc[i]) begin
                w_top_id = IDW'(i);
            end
        end
    end
`endif

    // Next-state and request/stack control.
    always_comb begin
        w_state_next = r_state;
        w_itr_next   = r_itr;
        w_id_next    = r_id;
        w_addr_next  = r_itr_addr;
        w_pend_clr   = '0;
        w_insvc_next = r_insvc;
        case (r_state)
            S_IDLE: begin
                if (w_any_elig) begin
                    w_state_next = S_REQ;
                    w_itr_next   = 1'b1;
                    w_id_next    = w_win_id;
                    w_addr_next  = vec_addr(w_win_id);
                end
            end
            S_REQ: begin
                // Request is held even if the source gets masked meanwhile.
                if (itr_ack) begin
                    w_state_next = S_SERV;
                    w_itr_next   = 1'b0;
                    w_pend_clr   = NSRC'(1) << r_id;
                    w_insvc_next = r_insvc | (NSRC'(1) << r_id);
                end
            end
            S_SERV: begin
                if (itr_ret) begin
                    // Pop: drop the lowest set bit (the top of the stack).
                    w_insvc_next = r_insvc & (r_insvc - NSRC'(1));
                    if (w_insvc_next == '0) begin
                        w_state_next = S_IDLE;
                    end
                end
`ifdef ITR_NEST_EN
                else if (w_any_elig && (w_win_id < w_top_id)) begin
                    // Preemption by a strictly higher-priority source.
                    w_state_next = S_REQ;
                    w_itr_next   = 1'b1;
                    w_id_next    = w_win_id;
                    w_addr_next  = vec_addr(w_win_id);
                end
`endif
            end
            default: begin
                w_state_next = S_IDLE;
                w_itr_next   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: edge detect, pending, mask, in-service set, request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_d    <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_insvc    <= '0;
            r_id       <= '0;
            r_itr      <= 1'b0;
            r_itr_addr <= MINSTW'(ITRBASE);
        end else begin
            r_src_d    <= src;
            r_pend     <= w_pend_next;
            r_mask     <= mask_wr ? mask_in : r_mask;
            r_insvc    <= w_insvc_next;
            r_id       <= w_id_next;
            r_itr      <= w_itr_next;
            r_itr_addr <= w_addr_next;
        end
    end

    assign mask_out = r_mask;
    assign pend     = r_pend;
    assign itr      = r_itr;
    assign itr_addr = r_itr_addr;
    assign busy     = |r_insvc;

endmodule
